// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter: shares the single register-file write port between the
// in-order writeback stage and the MUL/DIV unit. MDU results wait in a small
// FIFO and drain into idle writeback slots; a starvation counter requests a
// pipeline bubble when the FIFO head has waited too long.
// Optional feature: define WB_SCOREBOARD_EN to add the rd_busy output that
// flags destination registers with pending MDU results.
module rv32i_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_wb_en_in,
    input  logic [4:0]               pipe_wb_reg_in,
    input  logic [31:0]              pipe_wb_data_in,
    input  logic                     mdu_valid,
    input  logic [4:0]               mdu_reg,
    input  logic [31:0]              mdu_data,
    output logic                     mdu_ready,
    output logic                     pipe_stall,
    output logic                     wb_en_out,
    output logic [4:0]               wb_reg_out,
    output logic [31:0]              wb_data,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [31:0]              rd_busy
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_reg  [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic [DEPTH-1:0] kill_mask;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [SW-1:0]    starve_cnt;
    logic [SW-1:0]    starve_next;
    logic             stall_next;
    logic [CW-1:0]    count_next;

    logic full;
    logic push;
    logic pipe_wins;
    logic head_live;
    logic pop_live;
    logic pop_dead;
    logic pop;

    // A valid bit implies the slot is occupied, because pops clear it.
    assign full      = (fifo_count == CW'(DEPTH));
    assign mdu_ready = !full;
    assign push      = mdu_valid && mdu_ready;
    assign pipe_wins = pipe_wb_en_in && (pipe_wb_reg_in != 5'd0);
    assign head_live = (fifo_count != '0) && fifo_valid[rd_ptr];
    assign pop_dead  = (fifo_count != '0) && !fifo_valid[rd_ptr];
    assign pop_live  = head_live && !pipe_wins;
    assign pop       = pop_live || pop_dead;

    // A younger pipe write to the same register makes a buffered MDU result stale.
    for (genvar g = 0; g < DEPTH; g++) begin : g_kill
        assign kill_mask[g] = pipe_wins && (fifo_reg[g] == pipe_wb_reg_in);
    end

    // Occupancy follows pushes and pops; a simultaneous push and pop cancel out.
    always_comb begin
        count_next = fifo_count;
        if (push && !pop) begin
            count_next = fifo_count + CW'(1);
        end else if (!push && pop) begin
            count_next = fifo_count - CW'(1);
        end
    end

    // Count cycles a live head is blocked by the pipe; a full count yields one stall pulse.
    always_comb begin
        starve_next = starve_cnt;
        stall_next  = 1'b0;
        if (pop_live || (fifo_count == '0)) begin
            starve_next = '0;
        end else if (head_live) begin
            if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                starve_next = '0;
                stall_next  = 1'b1;
            end else begin
                starve_next = starve_cnt + SW'(1);
            end
        end
    end

    // FIFO payload storage is written only on an accepted push and needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= mdu_reg;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    // FIFO control state: kills first, then the pop clear, then the push wins its slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_valid <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            starve_cnt <= '0;
            pipe_stall <= 1'b0;
        end else begin
            fifo_valid <= fifo_valid & ~kill_mask;
            if (pop) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PW'(1);
            end
            if (push) begin
                fifo_valid[wr_ptr] <= (mdu_reg != 5'd0);
                wr_ptr             <= wr_ptr + PW'(1);
            end
            fifo_count <= count_next;
            starve_cnt <= starve_next;
            pipe_stall <= stall_next;
        end
    end

    // Register the winning write; address and data hold when nothing is written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en_out  <= 1'b0;
            wb_reg_out <= 5'd0;
            wb_data    <= 32'd0;
        end else if (pipe_wins) begin
            wb_en_out  <= 1'b1;
            wb_reg_out <= pipe_wb_reg_in;
            wb_data    <= pipe_wb_data_in;
        end else if (pop_live) begin
            wb_en_out  <= 1'b1;
            wb_reg_out <= fifo_reg[rd_ptr];
            wb_data    <= fifo_data[rd_ptr];
        end else begin
            wb_en_out  <= 1'b0;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_acc [DEPTH+1];

    // Busy bits: every live buffered destination plus the one being pushed now.
    assign busy_acc[0] = push ? (32'd1 << mdu_reg) : 32'd0;
    for (genvar g = 0; g < DEPTH; g++) begin : g_busy
        assign busy_acc[g+1] = busy_acc[g] |
                               (fifo_valid[g] ? (32'd1 << fifo_reg[g]) : 32'd0);
    end
    assign rd_busy = busy_acc[DEPTH] & ~32'd1;
`endif

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter: directed scenarios plus randomized traffic, checked
// against a queue-based model of the arbitration rules.
// Build with WB_SCOREBOARD_EN defined to also check rd_busy.
module tb_rv32i_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic                   clk;
    logic                   reset;
    logic                   pipe_wb_en_in;
    logic [4:0]             pipe_wb_reg_in;
    logic [31:0]            pipe_wb_data_in;
    logic                   mdu_valid;
    logic [4:0]             mdu_reg;
    logic [31:0]            mdu_data;
    logic                   mdu_ready;
    logic                   pipe_stall;
    logic                   wb_en_out;
    logic [4:0]             wb_reg_out;
    logic [31:0]            wb_data;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef WB_SCOREBOARD_EN
    logic [31:0]            rd_busy;
`endif

    rv32i_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_wb_en_in   (pipe_wb_en_in),
        .pipe_wb_reg_in  (pipe_wb_reg_in),
        .pipe_wb_data_in (pipe_wb_data_in),
        .mdu_valid       (mdu_valid),
        .mdu_reg         (mdu_reg),
        .mdu_data        (mdu_data),
        .mdu_ready       (mdu_ready),
        .pipe_stall      (pipe_stall),
        .wb_en_out       (wb_en_out),
        .wb_reg_out      (wb_reg_out),
        .wb_data         (wb_data),
        .fifo_count      (fifo_count)
`ifdef WB_SCOREBOARD_EN
        ,
        .rd_busy         (rd_busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    entry_t      q[$];
    int          starve;
    logic        expEn;
    logic        expStall;
    logic [4:0]  expReg;
    logic [31:0] expData;
    int          checks = 0;
    int          errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic void modelReset();
        q.delete();
        starve   = 0;
        expEn    = 1'b0;
        expStall = 1'b0;
        expReg   = 5'd0;
        expData  = 32'd0;
    endfunction

    // One cycle of the arbitration rules applied to the queue of buffered results.
    function automatic void modelStep(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                                      input logic mv, input logic [4:0] mr, input logic [31:0] md);
        logic pipe;
        logic accept;
        logic livePop;
        pipe    = pe && (pr != 5'd0);
        accept  = mv && (q.size() < DEPTH);
        livePop = 1'b0;
        expEn   = 1'b0;
        if (pipe) begin
            expEn   = 1'b1;
            expReg  = pr;
            expData = pd;
        end else if (q.size() > 0 && q[0].v) begin
            livePop = 1'b1;
            expEn   = 1'b1;
            expReg  = q[0].r;
            expData = q[0].d;
        end
        expStall = 1'b0;
        if (q.size() == 0 || livePop) begin
            starve = 0;
        end else if (q[0].v) begin
            starve++;
            if (starve == STARVE_LIMIT) begin
                starve   = 0;
                expStall = 1'b1;
            end
        end
        if (q.size() > 0 && (livePop || !q[0].v)) void'(q.pop_front());
        if (pipe) begin
            foreach (q[i]) if (q[i].r == pr) q[i].v = 1'b0;
        end
        if (accept) q.push_back('{v: (mr != 5'd0), r: mr, d: md});
    endfunction

`ifdef WB_SCOREBOARD_EN
    function automatic logic [31:0] modelBusy(input logic mv, input logic [4:0] mr);
        logic [31:0] b;
        b = 32'd0;
        foreach (q[i]) if (q[i].v) b[q[i].r] = 1'b1;
        if (mv && (q.size() < DEPTH)) b[mr] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction
`endif

    // Drive one cycle of inputs, check pre-edge state, advance, check registered outputs.
    task automatic applyStimulus(input logic pe, input logic [4:0] pr, input logic [31:0] pd,
                                 input logic mv, input logic [4:0] mr, input logic [31:0] md);
        pipe_wb_en_in   = pe;
        pipe_wb_reg_in  = pr;
        pipe_wb_data_in = pd;
        mdu_valid       = mv;
        mdu_reg         = mr;
        mdu_data        = md;
        #1;
        checkOutput("mdu_ready", 32'(mdu_ready), 32'(q.size() < DEPTH));
        checkOutput("fifo_count", 32'(fifo_count), 32'(q.size()));
`ifdef WB_SCOREBOARD_EN
        checkOutput("rd_busy", rd_busy, modelBusy(mv, mr));
`endif
        modelStep(pe, pr, pd, mv, mr, md);
        @(posedge clk);
        #1;
        checkOutput("wb_en_out", 32'(wb_en_out), 32'(expEn));
        if (expEn) begin
            checkOutput("wb_reg_out", 32'(wb_reg_out), 32'(expReg));
            checkOutput("wb_data", wb_data, expData);
        end
        checkOutput("pipe_stall", 32'(pipe_stall), 32'(expStall));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int stallAt;
        logic pending;
        int busyPct;

        clk             = 1'b0;
        reset           = 1'b1;
        pipe_wb_en_in   = 1'b0;
        pipe_wb_reg_in  = 5'd0;
        pipe_wb_data_in = 32'd0;
        mdu_valid       = 1'b0;
        mdu_reg         = 5'd0;
        mdu_data        = 32'd0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_wb_en", 32'(wb_en_out), 32'd0);
        checkOutput("reset_wb_reg", 32'(wb_reg_out), 32'd0);
        checkOutput("reset_wb_data", wb_data, 32'd0);
        checkOutput("reset_stall", 32'(pipe_stall), 32'd0);
        checkOutput("reset_count", 32'(fifo_count), 32'd0);
        checkOutput("reset_ready", 32'(mdu_ready), 32'd1);

        $display("[TB] idle-slot drain");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("drain_data", wb_data, 32'hDEADBEEF);
        idle(1);

        $display("[TB] pipe priority and starvation");
        stallAt = -1;
        applyStimulus(1'b1, 5'd3, 32'h300, 1'b1, 5'd7, 32'h777);
        for (int n = 1; n <= 12; n++) begin
            applyStimulus(!expStall, 5'd3, 32'h300 + 32'(n), 1'b0, 5'd0, 32'd0);
            if (pipe_stall && stallAt < 0) stallAt = n;
        end
        checkOutput("stall_latency", 32'(stallAt), 32'(STARVE_LIMIT));
        idle(2);

        $display("[TB] full FIFO");
        for (int k = 0; k < 4; k++)
            applyStimulus(!expStall, 5'd3, 32'h30 + 32'(k), 1'b1, 5'(10 + k), 32'hA0 + 32'(k));
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        checkOutput("full_ready", 32'(mdu_ready), 32'd0);
        pending = 1'b1;
        for (int n = 0; n < 14; n++) begin
            logic acc;
            acc = pending && (q.size() < DEPTH);
            applyStimulus(!expStall, 5'd3, 32'h40 + 32'(n), pending, 5'd14, 32'hE0E0);
            if (acc) pending = 1'b0;
        end
        idle(6);

        $display("[TB] kill");
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h11);
        applyStimulus(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
        idle(3);

        $display("[TB] x0 and scoreboard");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd12, 32'hC12);
        applyStimulus(1'b1, 5'd3, 32'h2, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b0, 5'd0, 32'd0);
        idle(3);

        $display("[TB] reset mid-operation");
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 5'd3, 32'h60 + 32'(k), 1'b1, 5'(20 + k), 32'hB0 + 32'(k));
        checkOutput("pre_reset_count", 32'(fifo_count), 32'd3);
        pipe_wb_en_in = 1'b0;
        mdu_valid     = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_count", 32'(fifo_count), 32'd0);
        checkOutput("async_wb_en", 32'(wb_en_out), 32'd0);
        checkOutput("async_ready", 32'(mdu_ready), 32'd1);
        checkOutput("async_stall", 32'(pipe_stall), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        idle(4);

        $display("[TB] randomized traffic");
        for (int phase = 0; phase < 3; phase++) begin
            busyPct = (phase == 0) ? 30 : ((phase == 1) ? 70 : 95);
            for (int n = 0; n < 150; n++) begin
                logic pe;
                logic mv;
                logic [4:0] pr;
                logic [4:0] mr;
                pe = ($urandom_range(99) < busyPct) && (!expStall || ($urandom_range(3) == 0));
                mv = ($urandom_range(1) == 1);
                pr = ($urandom_range(4) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
                mr = ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
                applyStimulus(pe, pr, $urandom, mv, mr, $urandom);
            end
            idle(8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
